// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite definitions: transfer-type and transfer-size encodings,
// response constants and the byte-lane mask helper used by subordinates.
// No ports (package).
// ---------------------------------------------------------------------------
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE     = 3'd0,
        HSIZE_HALF     = 3'd1,
        HSIZE_WORD     = 3'd2,
        HSIZE_DWORD    = 3'd3,
        HSIZE_WORD4    = 3'd4,
        HSIZE_WORD8    = 3'd5,
        HSIZE_WORD512  = 3'd6,
        HSIZE_WORD1024 = 3'd7
    } hsize_e;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Byte-lane mask for a transfer of 2^size bytes starting at byte lane
    // addr_lsbs, for buses up to 128 bits wide. Sizes of 16 bytes or more
    // saturate to all lanes; such sizes are rejected by the caller anyway
    // whenever they exceed the bus width.
    function automatic logic [15:0] lane_mask(input logic [2:0] size,
                                              input logic [3:0] addr_lsbs);
        logic [15:0] ones;
        if (size >= 3'd4)
            ones = 16'hFFFF;
        else
            ones = (16'd1 << (16'd1 << size)) - 16'd1;
        return ones << addr_lsbs;
    endfunction

endpackage

// File: rtl/ahb_sram_bank.sv
// ---------------------------------------------------------------------------
// ahb_sram_bank
// Byte-enabled single-port storage array: combinational read, synchronous
// byte-masked write. Contents are never reset.
// Ports:
//   HCLK   - clock
//   we     - write enable for this cycle
//   be     - per-byte write enables
//   addr   - word index (shared by read and write)
//   wdata  - write data
//   rdata  - read data of the word at addr (combinational)
// ---------------------------------------------------------------------------
module ahb_sram_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                    HCLK,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge HCLK) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i])
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ahb_sram_subordinate.sv
// ---------------------------------------------------------------------------
// ahb_sram_subordinate
// AHB-Lite subordinate memory model: byte-addressable SRAM with optional
// wait-state insertion and the two-cycle ERROR response for out-of-range,
// misaligned or oversized transfers.
// Ports:
//   HCLK, HRESETn       - clock, synchronous active-low reset
//   HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK
//                       - address-phase inputs (HBURST/HPROT/HMASTLOCK unused)
//   HWDATA, HWSTRB      - data-phase write data and byte strobes
//   HREADY              - bus-level ready (end of previous data phase)
//   HRDATA              - read data, held outside read data phases
//   HREADYOUT, HRESP    - subordinate ready and response
// ---------------------------------------------------------------------------
module ahb_sram_subordinate
    import ahb_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    MEM_BYTES   = 4096,
    parameter int                    WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    HSELx,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic [1:0]              HTRANS,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [2:0]              HBURST,
    input  logic [3:0]              HPROT,
    input  logic                    HMASTLOCK,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic [DATA_WIDTH/8-1:0] HWSTRB,
    input  logic                    HREADY,
    output logic [DATA_WIDTH-1:0]   HRDATA,
    output logic                    HREADYOUT,
    output logic                    HRESP
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int LB    = $clog2(NB);
    localparam int MW    = $clog2(MEM_BYTES);
    localparam int IW    = MW - LB;
    localparam int DEPTH = MEM_BYTES / NB;

    typedef enum logic [2:0] {IDLE, WAIT, XFER, ERR1, ERR2} state_e;

    state_e                state;
    logic [3:0]            wait_cnt;
    logic                  hreadyout_q;
    logic                  hresp_q;
    logic [DATA_WIDTH-1:0] rdata_hold;

    logic                  write_q;
    logic [IW-1:0]         word_idx_q;
    logic [NB-1:0]         mask_q;

    logic                  sample;
    logic                  can_capture;
    logic [ADDR_WIDTH-1:0] offset;
    logic                  range_err;
    logic                  align_err;
    logic                  size_err;
    logic                  cap_err;
    logic [15:0]           lm16;
    logic [NB-1:0]         mask_d;

    logic                  bank_we;
    logic [DATA_WIDTH-1:0] bank_rdata;
    logic [DATA_WIDTH-1:0] rd_masked;
    logic [DATA_WIDTH-1:0] rdata_out;

    // Address phase: decode and classify the incoming transfer
    assign sample      = HSELx && HREADY && HTRANS[1];
    assign can_capture = (state == IDLE) || (state == XFER) || (state == ERR2);

    // Unsigned wrap makes addresses below BASE_ADDR land far out of range,
    // so one upper-bits test covers both ends of the window.
    assign offset    = HADDR - BASE_ADDR;
    assign range_err = |offset[ADDR_WIDTH-1:MW];
    assign align_err = |(HADDR[6:0] & ((7'd1 << HSIZE) - 7'd1));
    assign size_err  = (32'(HSIZE) > LB);
    assign cap_err   = range_err || align_err || size_err;

    assign lm16   = lane_mask(HSIZE, 4'(HADDR[LB-1:0]));
    assign mask_d = lm16[NB-1:0];

    always_ff @(posedge HCLK) begin
        if (sample && can_capture) begin
            write_q    <= HWRITE;
            word_idx_q <= offset[MW-1:LB];
            mask_q     <= mask_d;
        end
    end

    // Data phase control: state, wait counter and registered responses
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            rdata_hold  <= '0;
        end else begin
            rdata_hold <= rdata_out;
            case (state)
                IDLE, XFER, ERR2: begin
                    if (sample) begin
                        if (cap_err) begin
                            state       <= ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state       <= WAIT;
                            wait_cnt    <= 4'(WAIT_STATES - 1);
                            hreadyout_q <= 1'b0;
                            hresp_q     <= HRESP_OKAY;
                        end else begin
                            state       <= XFER;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= HRESP_OKAY;
                        end
                    end else begin
                        state       <= IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state       <= XFER;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ERR1: begin
                    state       <= ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    state       <= IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    // Storage access in XFER; a write asserted alongside reset is dropped.
    // A read captured during a write's XFER sees the new data because the
    // write lands at the same edge that moves the read into its XFER.
    assign bank_we = HRESETn && (state == XFER) && write_q;

    ahb_sram_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_bank (
        .HCLK  (HCLK),
        .we    (bank_we),
        .be    (mask_q & HWSTRB),
        .addr  (word_idx_q),
        .wdata (HWDATA),
        .rdata (bank_rdata)
    );

    always_comb begin
        rd_masked = '0;
        for (int i = 0; i < NB; i++) begin
            if (mask_q[i])
                rd_masked[i*8 +: 8] = bank_rdata[i*8 +: 8];
        end
    end

    assign rdata_out = ((state == XFER) && !write_q) ? rd_masked : rdata_hold;

    assign HRDATA    = rdata_out;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

    logic unused_inputs;
    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], lm16};

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
module tb_ahb_sram_subordinate;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        hsel0, hsel3;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [3:0]  HWSTRB;

    logic [31:0] hrdata0, hrdata3;
    logic        hreadyout0, hreadyout3;
    logic        hresp0, hresp3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 HCLK = ~HCLK;

    ahb_sram_subordinate #(.WAIT_STATES(0)) dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(hsel0), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
        .HREADY(hreadyout0), .HRDATA(hrdata0), .HREADYOUT(hreadyout0), .HRESP(hresp0)
    );

    ahb_sram_subordinate #(.WAIT_STATES(3)) dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSELx(hsel3), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA), .HWSTRB(HWSTRB),
        .HREADY(hreadyout3), .HRDATA(hrdata3), .HREADYOUT(hreadyout3), .HRESP(hresp3)
    );

    // Inputs change and outputs are sampled on the falling edge.
    task automatic drv(input logic s0, input logic s3, input logic [31:0] a,
                       input logic w, input logic [2:0] sz);
        hsel0 = s0; hsel3 = s3; HADDR = a; HTRANS = 2'b10; HWRITE = w; HSIZE = sz;
    endtask

    task automatic idle();
        hsel0 = 1'b0; hsel3 = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        idle();
        repeat (2) @(negedge HCLK);
        n_cmp++; if (hreadyout0 !== 1'b1) begin n_err++; $display("FAIL rst_ready0 got=%b exp=1", hreadyout0); end
        n_cmp++; if (hresp0 !== 1'b0) begin n_err++; $display("FAIL rst_resp0 got=%b exp=0", hresp0); end
        n_cmp++; if (hrdata0 !== 32'h0) begin n_err++; $display("FAIL rst_rdata0 got=%h exp=0", hrdata0); end
        n_cmp++; if (hreadyout3 !== 1'b1) begin n_err++; $display("FAIL rst_ready3 got=%b exp=1", hreadyout3); end
        n_cmp++; if (hresp3 !== 1'b0) begin n_err++; $display("FAIL rst_resp3 got=%b exp=0", hresp3); end
        n_cmp++; if (hrdata3 !== 32'h0) begin n_err++; $display("FAIL rst_rdata3 got=%h exp=0", hrdata3); end
        HRESETn = 1'b1;
    endtask

    task automatic test_write_read();
        @(negedge HCLK) drv(1, 0, 32'h10, 1, 3'd2);
        @(negedge HCLK);
        n_cmp++; if (hreadyout0 !== 1'b1) begin n_err++; $display("FAIL wr_ready got=%b exp=1", hreadyout0); end
        HWDATA = 32'hDEADBEEF; HWSTRB = 4'hF; idle();
        @(negedge HCLK) drv(1, 0, 32'h10, 0, 3'd2);
        @(negedge HCLK);
        n_cmp++; if (hrdata0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data got=%h exp=deadbeef", hrdata0); end
        n_cmp++; if (hreadyout0 !== 1'b1) begin n_err++; $display("FAIL rd_ready got=%b exp=1", hreadyout0); end
        n_cmp++; if (hresp0 !== 1'b0) begin n_err++; $display("FAIL rd_resp got=%b exp=0", hresp0); end
        idle(); HWDATA = 32'h0;
        @(negedge HCLK);
        n_cmp++; if (hrdata0 !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_hold got=%h exp=deadbeef", hrdata0); end
    endtask

    task automatic test_byte_write();
        @(negedge HCLK) drv(1, 0, 32'h10, 1, 3'd2);
        @(negedge HCLK) HWDATA = 32'h11223344; HWSTRB = 4'hF; drv(1, 0, 32'h13, 1, 3'd0);
        @(negedge HCLK) HWDATA = 32'hAA000000; HWSTRB = 4'b1000; drv(1, 0, 32'h10, 0, 3'd2);
        @(negedge HCLK);
        n_cmp++; if (hrdata0 !== 32'hAA223344) begin n_err++; $display("FAIL byte_merge got=%h exp=aa223344", hrdata0); end
        drv(1, 0, 32'h12, 0, 3'd0);
        @(negedge HCLK);
        n_cmp++; if (hrdata0 !== 32'h00220000) begin n_err++; $display("FAIL byte_read_lane got=%h exp=00220000", hrdata0); end
        idle();
    endtask

    task automatic test_errors();
        @(negedge HCLK) drv(1, 0, 32'h0, 1, 3'd2);
        @(negedge HCLK) HWDATA = 32'hCAFEF00D; HWSTRB = 4'hF; drv(1, 0, 32'h1000, 0, 3'd2);
        @(negedge HCLK);
        n_cmp++; if (hreadyout0 !== 1'b0) begin n_err++; $display("FAIL oor_err1_ready got=%b exp=0", hreadyout0); end
        n_cmp++; if (hresp0 !== 1'b1) begin n_err++; $display("FAIL oor_err1_resp got=%b exp=1", hresp0); end
        idle(); HWDATA = 32'hFFFFFFFF;
        @(negedge HCLK);
        n_cmp++; if (hreadyout0 !== 1'b1) begin n_err++; $display("FAIL oor_err2_ready got=%b exp=1", hreadyout0); end
        n_cmp++; if (hresp0 !== 1'b1) begin n_err++; $display("FAIL oor_err2_resp got=%b exp=1", hresp0); end
        @(negedge HCLK);
        n_cmp++; if (hresp0 !== 1'b0 || hreadyout0 !== 1'b1) begin n_err++; $display("FAIL post_err_idle got=%b/%b exp=1/0", hreadyout0, hresp0); end
        drv(1, 0, 32'h2, 1, 3'd2);
        @(negedge HCLK);
        n_cmp++; if (hreadyout0 !== 1'b0 || hresp0 !== 1'b1) begin n_err++; $display("FAIL misal_err1 got=%b/%b exp=0/1", hreadyout0, hresp0); end
        idle();
        @(negedge HCLK);
        n_cmp++; if (hreadyout0 !== 1'b1 || hresp0 !== 1'b1) begin n_err++; $display("FAIL misal_err2 got=%b/%b exp=1/1", hreadyout0, hresp0); end
        drv(1, 0, 32'h8, 0, 3'd3);
        @(negedge HCLK);
        n_cmp++; if (hreadyout0 !== 1'b0 || hresp0 !== 1'b1) begin n_err++; $display("FAIL size_err1 got=%b/%b exp=0/1", hreadyout0, hresp0); end
        idle();
        @(negedge HCLK) drv(1, 0, 32'h0, 0, 3'd2);
        @(negedge HCLK);
        n_cmp++; if (hrdata0 !== 32'hCAFEF00D) begin n_err++; $display("FAIL err_no_write got=%h exp=cafef00d", hrdata0); end
        n_cmp++; if (hreadyout0 !== 1'b1 || hresp0 !== 1'b0) begin n_err++; $display("FAIL err_recover got=%b/%b exp=1/0", hreadyout0, hresp0); end
        idle();
    endtask

    task automatic test_back_to_back();
        @(negedge HCLK) drv(1, 0, 32'h40, 1, 3'd2);
        @(negedge HCLK) HWDATA = 32'h00000055; HWSTRB = 4'hF; drv(1, 0, 32'h40, 0, 3'd2);
        @(negedge HCLK);
        n_cmp++; if (hrdata0 !== 32'h00000055) begin n_err++; $display("FAIL b2b_raw got=%h exp=00000055", hrdata0); end
        n_cmp++; if (hreadyout0 !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b exp=1", hreadyout0); end
        idle();
    endtask

    task automatic test_wait_states();
        int  lowcnt;
        int  wr_low;
        bit  ok;
        @(negedge HCLK) drv(0, 1, 32'h20, 1, 3'd2);
        @(negedge HCLK) HWDATA = 32'h5A5AA5A5; HWSTRB = 4'hF; idle();
        ok = 0; wr_low = 0;
        for (int i = 0; i < 20; i++) begin
            if (hreadyout3) begin ok = 1; break; end
            wr_low++;
            @(negedge HCLK);
        end
        n_cmp++; if (!ok || wr_low != 3) begin n_err++; $display("FAIL ws_write_low got=%0d exp=3 done=%0d", wr_low, ok); end
        drv(0, 1, 32'h20, 0, 3'd2);
        lowcnt = 0; ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            if (hreadyout3) begin ok = 1; break; end
            lowcnt++;
        end
        idle();
        n_cmp++; if (!ok) begin n_err++; $display("FAIL ws_read_timeout got=no_ready exp=ready"); end
        n_cmp++; if (lowcnt != 3) begin n_err++; $display("FAIL ws_read_low got=%0d exp=3", lowcnt); end
        n_cmp++; if (hresp3 !== 1'b0) begin n_err++; $display("FAIL ws_resp got=%b exp=0", hresp3); end
        n_cmp++; if (hrdata3 !== 32'h5A5AA5A5) begin n_err++; $display("FAIL ws_rdata got=%h exp=5a5aa5a5", hrdata3); end
    endtask

    task automatic test_reset_in_wait();
        @(negedge HCLK) drv(0, 1, 32'h20, 0, 3'd2);
        @(negedge HCLK);
        n_cmp++; if (hreadyout3 !== 1'b0) begin n_err++; $display("FAIL rw_in_wait got=%b exp=0", hreadyout3); end
        idle(); HRESETn = 1'b0;
        @(negedge HCLK);
        n_cmp++; if (hreadyout3 !== 1'b1) begin n_err++; $display("FAIL rw_ready got=%b exp=1", hreadyout3); end
        n_cmp++; if (hresp3 !== 1'b0) begin n_err++; $display("FAIL rw_resp got=%b exp=0", hresp3); end
        n_cmp++; if (hrdata3 !== 32'h0) begin n_err++; $display("FAIL rw_rdata got=%h exp=0", hrdata3); end
        HRESETn = 1'b1;
        @(negedge HCLK);
        n_cmp++; if (hreadyout3 !== 1'b1) begin n_err++; $display("FAIL rw_after got=%b exp=1", hreadyout3); end
    endtask

    initial begin
        HBURST = 3'd0; HPROT = 4'd0; HMASTLOCK = 1'b0;
        HADDR = 32'h0; HSIZE = 3'd2; HWDATA = 32'h0; HWSTRB = 4'h0;
        test_reset();
        test_write_read();
        test_byte_write();
        test_errors();
        test_back_to_back();
        test_wait_states();
        test_reset_in_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule

// File: doc/ahb_sram_subordinate.md
Name: ahb_sram_subordinate

Overview:
AHB-Lite subordinate memory model. Attaches to the subordinate side of the AHB interface bundle and serves as the downstream consumer of manager transfers in VIP benches and smoke tests. Provides:
- byte-addressable SRAM storage
- programmable wait-state insertion
- the two-cycle ERROR response
The interface SVA checkers (idle no-wait, idle-on-error, HBURST stability) exercise against this block.

Parameters:
ADDR_WIDTH, 32, HADDR width.
DATA_WIDTH, 32, HWDATA/HRDATA width; one of 32, 64, 128.
MEM_BYTES, 4096, storage size in bytes; power of two; a multiple of DATA_WIDTH/8.
WAIT_STATES, 0, wait cycles inserted in each OKAY NONSEQ/SEQ data phase; range 0..15.
BASE_ADDR, 0, byte address of the first storage location.

Ports:
HCLK  input  1  bus clock
HRESETn  input  1  synchronous active-low reset
HSELx  input  1  subordinate select
HADDR  input  ADDR_WIDTH  address
HTRANS  input  2  transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3
HWRITE  input  1  1 = write
HSIZE  input  3  transfer size
HBURST  input  3  burst type; ignored apart from the protocol assertion
HPROT  input  4  ignored
HMASTLOCK  input  1  ignored
HWDATA  input  DATA_WIDTH  write data, valid in the data phase
HWSTRB  input  DATA_WIDTH/8  write byte strobes
HREADY  input  1  bus-level ready
HRDATA  output  DATA_WIDTH  read data
HREADYOUT  output  1  subordinate ready
HRESP  output  1  0 = OKAY, 1 = ERROR

Behaviour:
- Reset:
  - Clock and reset are decided: one clock, HCLK; HRESETn is synchronous and active-low.
  - During reset: HREADYOUT=1, HRESP=0, HRDATA=0, state=IDLE, wait counter=0.
  - Storage contents are not reset.
- Address-phase capture:
  - Sample condition: HSELx && HREADY && HTRANS[1].
  - On sample, register addr, write, size and lane mask.
  - Lane mask = size-derived mask shifted by addr[log2(DATA_WIDTH/8)-1:0].
- Error classification, evaluated at capture:
  - address outside [BASE_ADDR, BASE_ADDR+MEM_BYTES), or
  - address not aligned to 2^HSIZE, or
  - HSIZE > log2(DATA_WIDTH/8).
- IDLE/BUSY or unselected with HREADY=1: next data phase is zero-wait OKAY (HREADYOUT=1, HRESP=0). No storage access.
- State machine, states IDLE, WAIT, XFER, ERR1, ERR2:
  - IDLE: on a valid capture, go to ERR1 if the error classification hits. Otherwise go to WAIT if WAIT_STATES>0, else XFER.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements from WAIT_STATES-1. Go to XFER when it reaches 0.
  - XFER: HREADYOUT=1, HRESP=0.
    - Read: HRDATA = storage word at the captured address; only the lane-mask bytes are meaningful, others are 0.
    - Write: at the end of the cycle, write HWDATA bytes where lane mask & HWSTRB.
    - A new capture in the same cycle re-enters WAIT, XFER or ERR1 (back-to-back pipelining); otherwise go to IDLE.
  - ERR1: HREADYOUT=0, HRESP=1. Always go to ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. No storage write. A capture in this cycle is honoured like XFER; a manager issuing IDLE per protocol yields IDLE.
- Read-after-write: a read captured in the same cycle as a write's XFER returns the newly written data, with no bypass logic needed.
- HRDATA holds its last value outside XFER.
- Reset mid-transfer: state returns to IDLE and outputs return to reset values on the next HCLK edge. A pending write is dropped.
- Address offset = HADDR - BASE_ADDR, truncated to log2(MEM_BYTES) bits for indexing.

Decomposition:
- Shared package ahb_pkg:
  - htrans_e (IDLE, BUSY, NONSEQ, SEQ)
  - hsize_e (BYTE..WORD1024)
  - hresp constants OKAY=1'b0, ERROR=1'b1
  - lane-mask function lane_mask(size, addr_lsbs)
- One sub-module, ahb_sram_bank: byte-enabled single-port array with a combinational read and a synchronous write.
- FSM, capture registers and error classification stay in the top.

Test Plan:
- Reset, then write word 0xDEADBEEF at 0x10, then read 0x10, WAIT_STATES=0 -> HREADYOUT stays 1 and HRDATA=0xDEADBEEF in the read data phase.
- WAIT_STATES=3, read 0x20 -> HREADYOUT low for exactly 3 cycles, then 1 with HRESP=0.
- Byte write 0xAA to 0x13 (HSIZE=0, HWSTRB=4'b1000) over existing 0x11223344, then word read of 0x10 -> 0xAA223344.
- Read at BASE_ADDR+MEM_BYTES -> cycle1 HREADYOUT=0/HRESP=1, cycle2 HREADYOUT=1/HRESP=1; storage unchanged.
- Misaligned word write at 0x02 -> two-cycle ERROR, and a follow-up read of 0x00 returns the prior contents.
- Pipelined NONSEQ write 0x55 to 0x40 immediately followed by a read of 0x40, WAIT_STATES=0 -> read returns 0x55. Asserting HRESETn=0 during a WAIT state then gives HREADYOUT=1, HRESP=0 on the next edge.
